// File: rtl/color_sensor_target_if.sv
// color_sensor_target_if: local register load port and I2C-write notification
interface color_sensor_target_if;
    logic       load_en;
    logic [3:0] load_addr;
    logic [7:0] load_data;
    logic       reg_wr_valid;
    logic [3:0] reg_wr_addr;
    logic [7:0] reg_wr_data;
    modport master (output load_en, load_addr, load_data, input reg_wr_valid, reg_wr_addr, reg_wr_data);
    modport slave (input load_en, load_addr, load_data, output reg_wr_valid, reg_wr_addr, reg_wr_data);
endinterface

// File: rtl/color_sensor_target.sv
// color_sensor_target: I2C target emulating the RGB colour sensor's 16-byte register file
module color_sensor_target #(
    parameter logic [6:0] DEVICE_ADDRESS = 7'h44
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 scl,
    inout  wire                  sda,
    color_sensor_target_if.slave reg_port,
    output logic                 busy
);
    typedef enum logic [3:0] {IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RACK, IGNORE} state_t;
    state_t state, state_n;
    logic [1:0] scl_s, sda_s;
    logic scl_p, sda_p, scl_v, sda_v, start, stop, scl_rise, scl_fall;
    logic [2:0] cnt, cnt_n;
    logic [6:0] sr, sr_n, tx, tx_n;
    logic [3:0] ptr, ptr_n;
    logic [7:0] rf [16];
    logic [7:0] rx_byte, rd_byte;
    logic sda_low, sda_low_n, busy_n, rw, rw_n, wr_en, ld;

    assign scl_v = scl_s[1];
    assign sda_v = sda_s[1];
    assign start = scl_v & sda_p & ~sda_v;
    assign stop = scl_v & ~sda_p & sda_v;
    assign scl_rise = scl_v & ~scl_p;
    assign scl_fall = ~scl_v & scl_p;
    assign rx_byte = {sr, sda_v};
    assign rd_byte = rf[ptr];
    assign sda = sda_low ? 1'b0 : 1'bz;

    always_comb begin
        state_n = state;
        cnt_n = cnt;
        sr_n = sr;
        tx_n = tx;
        ptr_n = ptr;
        sda_low_n = sda_low;
        busy_n = busy;
        rw_n = rw;
        wr_en = 1'b0;
        ld = 1'b0;
        if (start) begin
            state_n = ADDR;
            cnt_n = '0;
            sda_low_n = 1'b0;
            busy_n = 1'b0;
        end else if (stop) begin
            state_n = IDLE;
            sda_low_n = 1'b0;
            busy_n = 1'b0;
        end else begin
            case (state)
                ADDR, PTR, WDATA: if (scl_rise) begin
                    sr_n = rx_byte[6:0];
                    cnt_n = cnt + 3'd1;
                    if (cnt == 3'd7) begin
                        if (state == ADDR) begin
                            state_n = (rx_byte[7:1] == DEVICE_ADDRESS) ? ADDR_ACK : IGNORE;
                            busy_n = rx_byte[7:1] == DEVICE_ADDRESS;
                            rw_n = rx_byte[0];
                        end else if (state == PTR) begin
                            ptr_n = rx_byte[3:0];
                            state_n = PTR_ACK;
                        end else begin
                            wr_en = 1'b1;
                            ptr_n = ptr + 4'd1;
                            state_n = WDATA_ACK;
                        end
                    end
                end
                // first fall after bit 8 starts the ACK, the next one ends it
                ADDR_ACK, PTR_ACK, WDATA_ACK: if (scl_fall) begin
                    sda_low_n = cnt == 3'd0;
                    cnt_n = (cnt == 3'd0) ? 3'd1 : 3'd0;
                    if (cnt != 3'd0) begin
                        state_n = (state == ADDR_ACK) ? PTR : WDATA;
                        ld = state == ADDR_ACK && rw;
                    end
                end
                RDATA: if (scl_fall) begin
                    sda_low_n = (cnt == 3'd7) ? 1'b0 : ~tx[6];
                    tx_n = {tx[5:0], 1'b0};
                    cnt_n = cnt + 3'd1;
                    state_n = (cnt == 3'd7) ? RACK : RDATA;
                end
                RACK: if (scl_rise && sda_v) begin
                    state_n = IGNORE;
                    busy_n = 1'b0;
                end else if (scl_fall) ld = 1'b1;
                default: ;
            endcase
            // bit 7 goes on the bus immediately; the rest waits in tx
            if (ld) begin
                tx_n = rd_byte[6:0];
                sda_low_n = ~rd_byte[7];
                ptr_n = ptr + 4'd1;
                cnt_n = '0;
                state_n = RDATA;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            scl_s <= '1;
            sda_s <= '1;
            scl_p <= 1'b1;
            sda_p <= 1'b1;
            state <= IDLE;
            cnt <= '0;
            sr <= '0;
            tx <= '0;
            ptr <= '0;
            sda_low <= 1'b0;
            busy <= 1'b0;
            rw <= 1'b0;
            for (int i = 0; i < 16; i++) rf[i] <= '0;
            reg_port.reg_wr_valid <= 1'b0;
            reg_port.reg_wr_addr <= '0;
            reg_port.reg_wr_data <= '0;
        end else begin
            scl_s <= {scl_s[0], scl};
            sda_s <= {sda_s[0], sda};
            scl_p <= scl_v;
            sda_p <= sda_v;
            state <= state_n;
            cnt <= cnt_n;
            sr <= sr_n;
            tx <= tx_n;
            ptr <= ptr_n;
            sda_low <= sda_low_n;
            busy <= busy_n;
            rw <= rw_n;
            reg_port.reg_wr_valid <= wr_en;
            if (wr_en) begin
                reg_port.reg_wr_addr <= ptr;
                reg_port.reg_wr_data <= rx_byte;
            end
            // the I2C write is issued last so it wins a same-index collision
            if (reg_port.load_en) rf[reg_port.load_addr] <= reg_port.load_data;
            if (wr_en) rf[ptr] <= rx_byte;
        end
    end
endmodule

// File: tb/tb_color_sensor_target.sv
// tb_color_sensor_target: bit-banged I2C master with a register-file model of the target
module tb_color_sensor_target;
    localparam int Q = 80;
    logic clock = 1'b0, reset = 1'b1, scl = 1'b1, m_low = 1'b0, watch = 1'b0;
    wire sda;
    logic busy;
    pullup (sda);
    assign sda = m_low ? 1'b0 : 1'bz;
    color_sensor_target_if ifc ();
    color_sensor_target #(.DEVICE_ADDRESS(7'h44)) dut (
        .clock(clock), .reset(reset), .scl(scl), .sda(sda), .reg_port(ifc.slave), .busy(busy)
    );
    always #5 clock = ~clock;

    typedef struct {
        logic [7:0] dev;
        logic [3:0] p;
        logic [7:0] d;
        logic       ack;
        logic [7:0] rd;
    } vec_t;

    int n_tests = 0, n_fail = 0, low_seen = 0, busy_seen = 0;
    logic [11:0] wr_q[$];
    logic [7:0] pend[$];
    logic [7:0] mdl [16];
    logic [3:0] mptr;

    always @(negedge clock) begin
        if (ifc.reg_wr_valid) wr_q.push_back({ifc.reg_wr_addr, ifc.reg_wr_data});
        if (watch && !m_low && sda == 1'b0) low_seen++;
        if (watch && busy) busy_seen++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic bit_io(input logic b, output logic r);
        m_low = ~b; #Q; scl = 1'b1; #Q; r = sda; #Q; scl = 1'b0; #Q;
    endtask

    task automatic i2c_start();
        m_low = 1'b0; #Q; scl = 1'b1; #Q; m_low = 1'b1; #Q; scl = 1'b0; #Q;
    endtask

    task automatic i2c_stop();
        m_low = 1'b1; #Q; scl = 1'b1; #Q; m_low = 1'b0; #Q;
    endtask

    task automatic wbyte(input logic [7:0] b, output logic ack);
        logic r;
        for (int i = 7; i >= 0; i--) bit_io(b[i], r);
        bit_io(1'b1, r);
        ack = ~r;
    endtask

    task automatic rbyte(input logic last, output logic [7:0] d);
        logic r;
        for (int i = 7; i >= 0; i--) begin
            bit_io(1'b1, r);
            d[i] = r;
        end
        bit_io(last, r);
    endtask

    task automatic load(input logic [3:0] a, input logic [7:0] d);
        ifc.load_en = 1'b1; ifc.load_addr = a; ifc.load_data = d;
        @(posedge clock); #2;
        ifc.load_en = 1'b0;
        mdl[a] = d;
    endtask

    // upper nibble of the pointer byte is random: the target must ignore it
    task automatic set_ptr(input logic [3:0] p);
        logic a;
        i2c_start();
        wbyte(8'h88, a); check("ptr_addr_ack", a, 1);
        wbyte({4'($urandom), p}, a); check("ptr_ack", a, 1);
        mptr = p;
    endtask

    task automatic write_bytes(input logic [3:0] p, input string tag);
        logic a;
        logic [7:0] b;
        logic [11:0] e[$];
        wr_q.delete();
        set_ptr(p);
        while (pend.size() > 0) begin
            b = pend.pop_front();
            wbyte(b, a); check({tag, "_ack"}, a, 1);
            e.push_back({mptr, b});
            mdl[mptr] = b;
            mptr++;
        end
        i2c_stop();
        check({tag, "_cnt"}, wr_q.size(), e.size());
        for (int k = 0; k < e.size() && k < wr_q.size(); k++) check({tag, "_pulse"}, wr_q[k], e[k]);
    endtask

    task automatic read_bytes(input int n, input string tag);
        logic a;
        logic [7:0] d;
        i2c_start();
        wbyte(8'h89, a); check({tag, "_ack"}, a, 1);
        for (int k = 0; k < n; k++) begin
            rbyte(k == n - 1, d);
            check({tag, "_data"}, d, mdl[mptr]);
            mptr++;
        end
        check({tag, "_rel"}, sda, 1);
        i2c_stop();
    endtask

    initial begin
        vec_t tbl [6];
        logic a;
        logic r;
        logic [7:0] d;
        int bad;
        tbl[0] = '{8'h88, 4'h4, 8'hA5, 1'b1, 8'hA5};
        tbl[1] = '{8'h88, 4'h7, 8'h3C, 1'b1, 8'h3C};
        tbl[2] = '{8'h90, 4'h4, 8'hFF, 1'b0, 8'hA5};
        tbl[3] = '{8'h88, 4'hF, 8'h81, 1'b1, 8'h81};
        tbl[4] = '{8'h8A, 4'h7, 8'h12, 1'b0, 8'h3C};
        tbl[5] = '{8'h00, 4'h7, 8'h99, 1'b0, 8'h3C};
        for (int i = 0; i < 16; i++) mdl[i] = '0;
        mptr = '0;
        ifc.load_en = 1'b0; ifc.load_addr = '0; ifc.load_data = '0;
        repeat (4) @(posedge clock);
        #2;
        check("rst_sda", sda, 1);
        check("rst_busy", busy, 0);
        check("rst_valid", ifc.reg_wr_valid, 0);
        check("rst_wr_addr", ifc.reg_wr_addr, 0);
        check("rst_wr_data", ifc.reg_wr_data, 0);
        check("rst_ptr", dut.ptr, 0);
        reset = 1'b0;
        repeat (2) @(posedge clock);
        #2;

        pend = '{8'h0D, 8'h3F};
        write_bytes(4'h1, "cfg");
        check("cfg_reg1", dut.rf[1], 8'h0D);
        check("cfg_reg2", dut.rf[2], 8'h3F);
        check("cfg_busy_after_stop", busy, 0);

        for (int k = 0; k < 6; k++) load(4'(9 + k), 8'(8'h11 * (k + 1)));
        set_ptr(4'h9);
        check("poll_busy", busy, 1);
        read_bytes(6, "poll");
        check("poll_ptr", dut.ptr, 15);

        wr_q.delete(); low_seen = 0; busy_seen = 0; watch = 1'b1;
        i2c_start();
        wbyte(8'h8A, a); check("miss_addr_ack", a, 0);
        wbyte(8'h00, a); check("miss_data_ack", a, 0);
        i2c_stop();
        watch = 1'b0;
        check("miss_sda_low", low_seen, 0);
        check("miss_busy", busy_seen, 0);
        check("miss_wr", wr_q.size(), 0);

        pend = '{8'hAA, 8'hBB};
        write_bytes(4'hF, "wrap");
        set_ptr(4'hF);
        read_bytes(2, "wrap_rd");

        // load_en stays on up to and including the cycle the I2C write lands
        set_ptr(4'h3);
        for (int i = 7; i >= 1; i--) bit_io(8'h77 >> i, r);
        ifc.load_en = 1'b1; ifc.load_addr = 4'h3; ifc.load_data = 8'h55;
        fork
            begin bit_io(1'b1, r); bit_io(1'b1, r); end
            begin
                for (int k = 0; k < 40 && !ifc.reg_wr_valid; k++) @(negedge clock);
                ifc.load_en = 1'b0;
            end
        join
        check("coll_ack", r, 0);
        i2c_stop();
        check("coll_reg3", dut.rf[3], 8'h77);
        mdl[3] = 8'h77; mptr = 4'h4;

        load(4'h5, 8'h00);
        set_ptr(4'h5);
        i2c_start();
        wbyte(8'h89, a); check("rstrd_ack", a, 1);
        check("rstrd_driving", sda, 0);
        reset = 1'b1;
        @(posedge clock); #2;
        check("rstrd_sda", sda, 1);
        check("rstrd_busy", busy, 0);
        bad = 0;
        for (int i = 0; i < 16; i++) if (dut.rf[i] != 8'h00) bad++;
        check("rstrd_regs", bad, 0);
        @(posedge clock); #2;
        reset = 1'b0;
        for (int i = 0; i < 16; i++) mdl[i] = '0;
        mptr = '0;
        repeat (2) @(posedge clock);
        #2;
        pend = '{8'hC3};
        write_bytes(4'h2, "post_rst");
        set_ptr(4'h2);
        read_bytes(1, "post_rst_rd");

        for (int i = 0; i < 6; i++) begin
            i2c_start();
            wbyte(tbl[i].dev, a); check("tbl_addr_ack", a, tbl[i].ack);
            wbyte({4'h0, tbl[i].p}, a);
            wbyte(tbl[i].d, a);
            i2c_stop();
            if (tbl[i].dev[7:1] == 7'h44) mdl[tbl[i].p] = tbl[i].d;
            set_ptr(tbl[i].p);
            i2c_start();
            wbyte(8'h89, a);
            rbyte(1'b1, d);
            i2c_stop();
            check("tbl_read", d, tbl[i].rd);
            mptr++;
        end

        for (int it = 0; it < 16; it++) begin
            case ($urandom_range(0, 2))
                0: load(4'($urandom_range(0, 15)), 8'($urandom));
                1: begin
                    for (int k = $urandom_range(1, 3); k > 0; k--) pend.push_back(8'($urandom));
                    write_bytes(4'($urandom_range(0, 15)), "rnd_wr");
                end
                default: begin
                    if ($urandom_range(0, 1) == 1) set_ptr(4'($urandom_range(0, 15)));
                    read_bytes($urandom_range(1, 3), "rnd_rd");
                end
            endcase
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
